video_sprite_overlay: RTL and testbench

VIDEO_SPRITE_OVERLAY -- requirements
Module: video_sprite_overlay

---
 rtl/video_sprite_overlay.sv | 123 ++++++++++++
 tb/tb_video_sprite_overlay.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/video_sprite_overlay.sv
// Composites a solid SPRITE_W x SPRITE_H rectangle onto a pixel stream with one cycle latency.
// Build option OVERLAY_OUTLINE_EN draws only the rectangle's one-pixel border.
module video_sprite_overlay #(
    parameter int unsigned SPRITE_W     = 16,
    parameter int unsigned SPRITE_H     = 16,
    parameter logic [23:0] SPRITE_COLOR = 24'hFF8000
) (
    input  logic        pixel_clock,
    input  logic        reset_n,
    input  logic [23:0] in_rgb,
    input  logic        in_enable,
    input  logic        in_vsync,
    input  logic        in_hsync,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    input  logic        pos_valid,
    output logic        pos_ready,
    output logic [23:0] out_rgb,
    output logic        out_enable,
    output logic        out_vsync,
    output logic        out_hsync
);

    localparam logic [10:0] CMAX = 11'd2047;
    localparam logic [11:0] W12  = 12'(SPRITE_W);
    localparam logic [11:0] H12  = 12'(SPRITE_H);

    logic [10:0] r_cx, r_cy;
    logic [10:0] r_act_x, r_act_y;
    logic [10:0] r_pend_x, r_pend_y;
    logic        r_pend_full, r_pos_ready;
    logic [23:0] r_out_rgb;
    logic        r_out_enable, r_out_vsync, r_out_hsync;

    logic        w_fall, w_xfer, w_apply;
    logic [11:0] w_cx, w_cy, w_ax, w_ay, w_xe, w_ye;
    logic        w_in_x, w_in_y, w_hit;

    // The delayed enable doubles as the previous-cycle enable for edge detection.
    assign w_fall  = r_out_enable & ~in_enable;
    assign w_xfer  = pos_valid & r_pos_ready;
    assign w_apply = in_vsync & r_pend_full;

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            r_cx <= '0;
            r_cy <= '0;
        end else begin
            if (in_enable) begin
                if (r_cx != CMAX) r_cx <= r_cx + 11'd1;
            end else if (w_fall) begin
                r_cx <= '0;
            end
            if (in_vsync)
                r_cy <= '0;
            else if (w_fall && r_cy != CMAX)
                r_cy <= r_cy + 11'd1;
        end
    end

    // Pending slot holds one request; it only reaches the active position on vsync,
    // so a frame is always drawn with a single placement.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            r_act_x     <= '0;
            r_act_y     <= '0;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_pend_full <= 1'b0;
            r_pos_ready <= 1'b1;
        end else if (w_apply) begin
            r_act_x     <= r_pend_x;
            r_act_y     <= r_pend_y;
            r_pend_full <= 1'b0;
            r_pos_ready <= 1'b1;
        end else if (w_xfer) begin
            r_pend_x    <= pos_x;
            r_pend_y    <= pos_y;
            r_pend_full <= 1'b1;
            r_pos_ready <= 1'b0;
        end
    end

    // 12-bit bounds so a sprite placed near 2047 cannot wrap onto column/row 0.
    assign w_cx   = {1'b0, r_cx};
    assign w_cy   = {1'b0, r_cy};
    assign w_ax   = {1'b0, r_act_x};
    assign w_ay   = {1'b0, r_act_y};
    assign w_xe   = w_ax + W12;
    assign w_ye   = w_ay + H12;
    assign w_in_x = (w_cx >= w_ax) && (w_cx < w_xe);
    assign w_in_y = (w_cy >= w_ay) && (w_cy < w_ye);

`ifdef OVERLAY_OUTLINE_EN
    logic w_edge;
    assign w_edge = (w_cx == w_ax) || (w_cx == w_xe - 12'd1) ||
                    (w_cy == w_ay) || (w_cy == w_ye - 12'd1);
    assign w_hit  = in_enable && w_in_x && w_in_y && w_edge;
`else
    assign w_hit  = in_enable && w_in_x && w_in_y;
`endif

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            r_out_rgb    <= '0;
            r_out_enable <= 1'b0;
            r_out_vsync  <= 1'b0;
            r_out_hsync  <= 1'b0;
        end else begin
            r_out_rgb    <= w_hit ? SPRITE_COLOR : in_rgb;
            r_out_enable <= in_enable;
            r_out_vsync  <= in_vsync;
            r_out_hsync  <= in_hsync;
        end
    end

    assign pos_ready  = r_pos_ready;
    assign out_rgb    = r_out_rgb;
    assign out_enable = r_out_enable;
    assign out_vsync  = r_out_vsync;
    assign out_hsync  = r_out_hsync;

endmodule

// File: tb/tb_video_sprite_overlay.sv
// Random-pixel frames checked against a frame-level placement model of the sprite overlay.
module tb_video_sprite_overlay;

    localparam int SW = 16;
    localparam int SH = 16;
    localparam logic [23:0] COL = 24'hFF8000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] in_rgb;
    logic        in_enable, in_vsync, in_hsync;
    logic [10:0] pos_x, pos_y;
    logic        pos_valid;
    logic        pos_ready;
    logic [23:0] out_rgb;
    logic        out_enable, out_vsync, out_hsync;

    video_sprite_overlay dut (
        .pixel_clock(clk),
        .reset_n    (reset_n),
        .in_rgb     (in_rgb),
        .in_enable  (in_enable),
        .in_vsync   (in_vsync),
        .in_hsync   (in_hsync),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .out_rgb    (out_rgb),
        .out_enable (out_enable),
        .out_vsync  (out_vsync),
        .out_hsync  (out_hsync)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    // model: sprite placement in force for this frame, and the one queued request
    int ax = 0, ay = 0, px_q = 0, py_q = 0;
    bit m_full = 1'b0;
    bit rnd_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit hit(input int x, input int y);
        int cx, cy;
        bit r;
        cx = (x > 2047) ? 2047 : x;
        cy = (y > 2047) ? 2047 : y;
        r  = cx >= ax && cx < ax + SW && cy >= ay && cy < ay + SH;
`ifdef OVERLAY_OUTLINE_EN
        r  = r && (cx == ax || cx == ax + SW - 1 || cy == ay || cy == ay + SH - 1);
`endif
        return r;
    endfunction

    // One pixel clock: x,y are the raster coordinates the generator is producing.
    task automatic step(input bit en, input bit vs, input bit hs, input int x, input int y,
                        input bit v, input int qx, input int qy, input bit rst = 1'b0);
        logic [23:0] rgb;
        logic [26:0] exp;
        bit rdy;
        rgb = 24'($urandom);
        rdy = !m_full;
        chk("ready", {31'd0, pos_ready}, {31'd0, rdy});
        if (rst) exp = '0;
        else     exp = {(en && hit(x, y)) ? COL : rgb, en, vs, hs};
        reset_n   = !rst;
        in_rgb    = rgb;
        in_enable = en;
        in_vsync  = vs;
        in_hsync  = hs;
        pos_valid = v;
        pos_x     = 11'(qx);
        pos_y     = 11'(qy);
        @(posedge clk);
        #1;
        chk(rst ? "reset_out" : (en ? "pixel" : "blank"),
            {5'd0, out_rgb, out_enable, out_vsync, out_hsync}, {5'd0, exp});
        if (rst) begin
            ax = 0; ay = 0; m_full = 1'b0;
        end else if (vs && m_full) begin
            ax = px_q; ay = py_q; m_full = 1'b0;
        end else if (v && rdy) begin
            px_q = qx; py_q = qy; m_full = 1'b1;
        end
    endtask

    task automatic rs(input bit en, input bit vs, input bit hs, input int x, input int y);
        bit v;
        v = rnd_on && ($urandom_range(0, 59) == 0);
        step(en, vs, hs, x, y, v, int'($urandom_range(0, 60)), int'($urandom_range(0, 45)));
    endtask

    task automatic frame(input int w, input int h, input bit vreq = 1'b0,
                         input int vx = 0, input int vy = 0);
        if (vreq) step(0, 1, 0, 0, 0, 1'b1, vx, vy);
        else      rs(0, 1, 0, 0, 0);
        repeat (3) rs(0, 0, 0, 0, 0);
        for (int y = 0; y < h; y++) begin
            rs(0, 0, 1, 0, 0);
            rs(0, 0, 0, 0, 0);
            for (int x = 0; x < w; x++) rs(1, 0, 0, x, y);
            rs(0, 0, 0, 0, 0);
        end
    endtask

    task automatic req(input int qx, input int qy);
        step(0, 0, 0, 0, 0, 1'b1, qx, qy);
    endtask

    initial begin
        reset_n = 1'b0; in_rgb = '0; in_enable = 1'b0; in_vsync = 1'b0; in_hsync = 1'b0;
        pos_x = '0; pos_y = '0; pos_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        repeat (2) step(0, 0, 0, 0, 0, 1'b1, 30, 30, 1'b1);

        // reset position is (0,0); a request on the vsync cycle waits a whole frame
        frame(48, 36, 1'b1, 20, 10);
        frame(48, 36);
        // partially off the right/bottom edge: clipped, no wrap to row/col 0
        req(40, 30);
        frame(48, 36);
        req(0, 0);
        frame(48, 36);

        rnd_on = 1'b1;
        repeat (6) frame(48, 36);
        rnd_on = 1'b0;
        frame(48, 36);

        // reset mid-line discards the pending request
        req(5, 5);
        frame(48, 36);
        step(0, 1, 0, 0, 0, 1'b0, 0, 0);
        req(20, 20);
        step(0, 0, 1, 0, 0, 1'b0, 0, 0);
        for (int x = 0; x < 5; x++) step(1, 0, 0, x, 0, 1'b0, 0, 0);
        step(1, 0, 0, 5, 0, 1'b0, 0, 0, 1'b1);
        repeat (3) step(0, 0, 0, 0, 0, 1'b0, 0, 0);
        frame(48, 36);

        // column and row counters saturate at 2047
        req(2040, 0);
        frame(2100, 1);
        req(0, 2040);
        frame(2, 2060);

        repeat (2) step(0, 0, 0, 0, 0, 1'b0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
